// File: rtl/lc3_controller.sv
// Multicycle control FSM for an LC-3 datapath: sequences fetch/decode/execute/
// memory/writeback/PC-update stages, with bounded memory waits and a retire count.
module lc3_controller #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      instr_in,
  input  logic             complete_instr,
  input  logic             complete_data,
  input  logic [2:0]       psr,
  output logic             enable_fetch,
  output logic             enable_decode,
  output logic             enable_execute,
  output logic             enable_writeback,
  output logic             enable_updatePC,
  output logic [1:0]       W_Control,
  output logic [1:0]       mem_state,
  output logic             br_taken,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // S_RESET is held only while reset is high, so the first cycle after
  // release is a clean FETCH rather than one already acting on its inputs.
  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM_IND,
    S_MEM_READ,
    S_MEM_WRITE,
    S_WRITEBACK,
    S_UPDATE_PC
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       ir_q;
  logic [WAIT_W-1:0] wait_q;
  logic [3:0]        opcode;
  logic              waiting;
  logic              done;
  logic              expired;
  logic              unused_ir_bits;

  assign opcode = ir_q[15:12];
  // Operand fields are consumed by the datapath, not by this controller.
  assign unused_ir_bits = ^ir_q[8:0];

  function automatic logic [1:0] mem_code(input state_e s);
    case (s)
      S_MEM_IND:   return 2'd0;
      S_MEM_READ:  return 2'd1;
      S_MEM_WRITE: return 2'd2;
      default:     return 2'd3;
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    waiting = (state_q == S_FETCH) || (state_q == S_MEM_IND) ||
              (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    done    = (state_q == S_FETCH) ? complete_instr : complete_data;
    expired = waiting && !done && (wait_q == WAIT_W'(WAIT_MAX - 1));

    case (state_q)
      S_RESET:     state_d = S_FETCH;
      S_FETCH:     if (complete_instr) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (opcode)
          OP_LDI, OP_STI:                 state_d = S_MEM_IND;
          OP_LD, OP_LDR:                  state_d = S_MEM_READ;
          OP_ST, OP_STR:                  state_d = S_MEM_WRITE;
          OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = S_WRITEBACK;
          default:                        state_d = S_UPDATE_PC;
        endcase
      end
      S_MEM_IND: begin
        if (complete_data) state_d = (opcode == OP_STI) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ:  if (complete_data) state_d = S_WRITEBACK;
      S_MEM_WRITE: if (complete_data) state_d = S_UPDATE_PC;
      S_WRITEBACK: state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase

    // A stalled wait abandons the instruction and retires it without writeback.
    if (expired) state_d = S_UPDATE_PC;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_RESET;
      ir_q             <= '0;
      wait_q           <= '0;
      enable_fetch     <= 1'b0;
      enable_decode    <= 1'b0;
      enable_execute   <= 1'b0;
      enable_writeback <= 1'b0;
      enable_updatePC  <= 1'b0;
      W_Control        <= 2'd0;
      mem_state        <= 2'd3;
      br_taken         <= 1'b0;
      mem_timeout      <= 1'b0;
      instr_count      <= '0;
    end else begin
      state_q          <= state_d;
      enable_fetch     <= (state_d == S_FETCH);
      enable_decode    <= (state_d == S_DECODE);
      enable_execute   <= (state_d == S_EXECUTE);
      enable_writeback <= (state_d == S_WRITEBACK);
      enable_updatePC  <= (state_d == S_UPDATE_PC);
      mem_state        <= mem_code(state_d);

      if (state_q == S_FETCH && complete_instr) ir_q <= instr_in;

      if (state_d != state_q) wait_q <= '0;
      else if (waiting)       wait_q <= wait_q + 1'b1;

      if (expired) mem_timeout <= 1'b1;

      if (state_q == S_UPDATE_PC) instr_count <= instr_count + 1'b1;

      if (state_q == S_EXECUTE) begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: W_Control <= 2'd0;
          OP_LD, OP_LDR, OP_LDI:  W_Control <= 2'd1;
          OP_LEA:                 W_Control <= 2'd2;
          default:                ;
        endcase
        case (opcode)
          OP_BR:   br_taken <= |(ir_q[11:9] & psr);
          OP_JMP:  br_taken <= 1'b1;
          default: br_taken <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lc3_controller.sv
// Directed bench for lc3_controller: walks each instruction class cycle by cycle
// and checks stage enables, memory state, flags and the retire counter.
module tb_lc3_controller;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [15:0]      instr_in;
  logic             complete_instr;
  logic             complete_data;
  logic [2:0]       psr;
  logic             enable_fetch, enable_decode, enable_execute;
  logic             enable_writeback, enable_updatePC;
  logic [1:0]       W_Control;
  logic [1:0]       mem_state;
  logic             br_taken;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_count;
  logic [4:0]       en;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] EN_0 = 5'b00000;
  localparam logic [4:0] EN_F = 5'b10000;
  localparam logic [4:0] EN_D = 5'b01000;
  localparam logic [4:0] EN_E = 5'b00100;
  localparam logic [4:0] EN_W = 5'b00010;
  localparam logic [4:0] EN_U = 5'b00001;

  lc3_controller #(.WAIT_MAX(15), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .instr_in         (instr_in),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .psr              (psr),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .enable_updatePC  (enable_updatePC),
    .W_Control        (W_Control),
    .mem_state        (mem_state),
    .br_taken         (br_taken),
    .mem_timeout      (mem_timeout),
    .instr_count      (instr_count)
  );

  assign en = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC};

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, half a period after they update.
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic stage(input string tag, input logic [4:0] exp_en);
    cyc();
    chk(tag, 32'(en), 32'(exp_en));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"},    32'(en),          32'(EN_0));
    chk({tag, "_ms"},    32'(mem_state),   32'd3);
    chk({tag, "_wctl"},  32'(W_Control),   32'd0);
    chk({tag, "_br"},    32'(br_taken),    32'd0);
    chk({tag, "_tmo"},   32'(mem_timeout), 32'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    instr_in       = 16'h0000;
    complete_instr = 1'b0;
    complete_data  = 1'b0;
    psr            = 3'b000;
    repeat (2) cyc();
    chk_reset_vals("reset");

    // ADD R0,R1,R2: F D E W U
    reset          = 1'b0;
    instr_in       = 16'h1042;
    complete_instr = 1'b1;
    stage("add_fetch", EN_F);
    chk("add_fetch_ms", 32'(mem_state), 32'd3);
    stage("add_decode", EN_D);
    stage("add_execute", EN_E);
    stage("add_wb", EN_W);
    chk("add_wctl", 32'(W_Control), 32'd0);
    stage("add_upc", EN_U);
    stage("ldi_fetch", EN_F);
    chk("add_count", 32'(instr_count), 32'd1);

    // LDI with each data access completing on its 4th cycle: 13 cycles total
    instr_in = 16'hA205;
    stage("ldi_decode", EN_D);
    stage("ldi_execute", EN_E);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ldi_ind_ms", 32'(mem_state), 32'd0);
      chk("ldi_ind_en", 32'(en), 32'(EN_0));
      if (i == 3) complete_data = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ldi_read_ms", 32'(mem_state), 32'd1);
      complete_data = (i == 3);
    end
    stage("ldi_wb", EN_W);
    chk("ldi_wctl", 32'(W_Control), 32'd1);
    chk("ldi_wb_ms", 32'(mem_state), 32'd3);
    complete_data = 1'b0;
    stage("ldi_upc", EN_U);
    stage("br1_fetch", EN_F);
    chk("ldi_count", 32'(instr_count), 32'd2);

    // BRz taken (Z set)
    instr_in = 16'h0403;
    psr      = 3'b010;
    stage("br1_decode", EN_D);
    stage("br1_execute", EN_E);
    stage("br1_upc", EN_U);
    chk("br1_taken", 32'(br_taken), 32'd1);
    chk("br1_wctl_held", 32'(W_Control), 32'd1);
    stage("br2_fetch", EN_F);
    chk("br1_count", 32'(instr_count), 32'd3);

    // BRz not taken (N set)
    psr = 3'b100;
    stage("br2_decode", EN_D);
    stage("br2_execute", EN_E);
    stage("br2_upc", EN_U);
    chk("br2_taken", 32'(br_taken), 32'd0);
    stage("jmp_fetch", EN_F);
    chk("br2_count", 32'(instr_count), 32'd4);

    // JMP always redirects
    instr_in = 16'hC1C0;
    stage("jmp_decode", EN_D);
    stage("jmp_execute", EN_E);
    stage("jmp_upc", EN_U);
    chk("jmp_taken", 32'(br_taken), 32'd1);
    stage("lea_fetch", EN_F);

    // LEA selects the PC writeback source and clears br_taken
    instr_in = 16'hE200;
    stage("lea_decode", EN_D);
    stage("lea_execute", EN_E);
    stage("lea_wb", EN_W);
    chk("lea_wctl", 32'(W_Control), 32'd2);
    chk("lea_br", 32'(br_taken), 32'd0);
    stage("lea_upc", EN_U);
    stage("sti_fetch", EN_F);
    chk("lea_count", 32'(instr_count), 32'd6);

    // STI with data already complete: 6 cycles, W_Control unchanged
    instr_in      = 16'hB000;
    complete_data = 1'b1;
    stage("sti_decode", EN_D);
    stage("sti_execute", EN_E);
    cyc();
    chk("sti_ind_ms", 32'(mem_state), 32'd0);
    cyc();
    chk("sti_write_ms", 32'(mem_state), 32'd2);
    stage("sti_upc", EN_U);
    chk("sti_wctl_held", 32'(W_Control), 32'd2);
    stage("ldr_fetch", EN_F);
    chk("sti_count", 32'(instr_count), 32'd7);

    // LDR completing on the last allowed wait cycle: completion beats timeout
    complete_data = 1'b0;
    instr_in      = 16'h6000;
    stage("ldr_decode", EN_D);
    stage("ldr_execute", EN_E);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("ldr_read_ms", 32'(mem_state), 32'd1);
      if (i == 14) complete_data = 1'b1;
    end
    stage("ldr_wb", EN_W);
    chk("ldr_no_timeout", 32'(mem_timeout), 32'd0);
    complete_data = 1'b0;
    stage("ldr_upc", EN_U);
    stage("ld_fetch", EN_F);
    chk("ldr_count", 32'(instr_count), 32'd8);

    // LD with no data completion: 15 wait cycles then timeout to UPDATE_PC
    instr_in = 16'h2000;
    stage("ld_decode", EN_D);
    stage("ld_execute", EN_E);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("ld_read_ms", 32'(mem_state), 32'd1);
      chk("ld_wait_en", 32'(en), 32'(EN_0));
    end
    chk("ld_pre_timeout", 32'(mem_timeout), 32'd0);
    stage("ld_timeout_upc", EN_U);
    chk("ld_timeout", 32'(mem_timeout), 32'd1);
    chk("ld_timeout_ms", 32'(mem_state), 32'd3);
    stage("st_fetch", EN_F);
    chk("ld_timeout_sticky", 32'(mem_timeout), 32'd1);
    chk("ld_count", 32'(instr_count), 32'd9);

    // ST interrupted by reset while waiting in MEM_WRITE
    instr_in = 16'h3000;
    stage("st_decode", EN_D);
    stage("st_execute", EN_E);
    cyc();
    chk("st_write_ms", 32'(mem_state), 32'd2);
    cyc();
    chk("st_write_ms2", 32'(mem_state), 32'd2);
    reset = 1'b1;
    cyc();
    chk_reset_vals("midreset");
    reset    = 1'b0;
    instr_in = 16'hD000;
    stage("post_reset_fetch", EN_F);
    chk("post_reset_count", 32'(instr_count), 32'd0);

    // Reserved opcode 1101 runs as a 4-cycle NOP; 16 of them wrap a 4-bit count
    for (int i = 1; i <= 15; i++) begin
      stage("nop_decode", EN_D);
      stage("nop_execute", EN_E);
      stage("nop_upc", EN_U);
      stage("nop_fetch", EN_F);
      chk("nop_count", 32'(instr_count), 32'(i));
    end
    stage("wrap_decode", EN_D);
    stage("wrap_execute", EN_E);
    stage("wrap_upc", EN_U);
    stage("wrap_fetch", EN_F);
    chk("wrap_count", 32'(instr_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 The module SHALL have a parameter WAIT_MAX, default 15, giving the maximum number of cycles spent in any wait state before a timeout.
REQ-002 The module SHALL have a parameter CNT_W, default 16, giving the width of instr_count.
REQ-003 Port clock, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: reset; synchronous, active-high.
REQ-005 Port instr_in, input, 16 bits: instruction word from instruction memory.
REQ-006 Port complete_instr, input, 1 bit: instruction-memory read done.
REQ-007 Port complete_data, input, 1 bit: data-memory access done.
REQ-008 Port psr, input, 3 bits: N,Z,P flags from the writeback stage, with bit 2 = N.
REQ-009 Port enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC, output, 1 bit each: stage enables.
REQ-010 Port W_Control, output, 2 bits: writeback source select; 0 = ALU, 1 = memory, 2 = PC/LEA.
REQ-011 Port mem_state, output, 2 bits: 0 = indirect read, 1 = data read, 2 = data write, 3 = idle.
REQ-012 Port br_taken, output, 1 bit: branch/jump redirect for the PC update.
REQ-013 Port mem_timeout, output, 1 bit: sticky wait-timeout flag.
REQ-014 Port instr_count, output, CNT_W bits: retired-instruction count.

Function
REQ-015 The block SHALL be a multicycle Moore FSM with states FETCH, DECODE, EXECUTE, MEM_IND, MEM_READ, MEM_WRITE, WRITEBACK, UPDATE_PC; each stage enable is high only in its own state, and at most one enable is high per cycle.
REQ-016 In FETCH, the block SHALL assert enable_fetch and hold FETCH until complete_instr = 1; on that edge it SHALL latch instr_in into an internal ir and go to DECODE.
REQ-017 In DECODE, the block SHALL assert enable_decode for exactly 1 cycle, then go to EXECUTE.
REQ-018 In EXECUTE, the block SHALL assert enable_execute for 1 cycle and branch on ir[15:12]:
- LDI 1010 or STI 1011 -> MEM_IND
- LD 0010 or LDR 0110 -> MEM_READ
- ST 0011 or STR 0111 -> MEM_WRITE
- ADD 0001, AND 0101, NOT 1001, LEA 1110 -> WRITEBACK
- BR 0000, JMP 1100 -> UPDATE_PC
- any other opcode -> UPDATE_PC, executed as a NOP
REQ-019 In MEM_IND, mem_state SHALL be 0; on complete_data the FSM SHALL go to MEM_READ for LDI or to MEM_WRITE for STI.
REQ-020 In MEM_READ, mem_state SHALL be 1; on complete_data the FSM SHALL go to WRITEBACK.
REQ-021 In MEM_WRITE, mem_state SHALL be 2; on complete_data the FSM SHALL go to UPDATE_PC.
REQ-022 mem_state SHALL be 3 in all other states.
REQ-023 complete_data SHALL be ignored outside the MEM_* states, and complete_instr outside FETCH.
REQ-024 In WRITEBACK, enable_writeback SHALL be high for exactly 1 cycle.
REQ-025 W_Control SHALL be a registered output, updated on the EXECUTE edge and held until the next EXECUTE: 0 for ADD/AND/NOT, 1 for LD/LDR/LDI, 2 for LEA, and unchanged for all other opcodes.
REQ-026 On the EXECUTE edge, br_taken SHALL be registered as follows and held until the next EXECUTE edge:
- BR: |(ir[11:9] & psr)
- JMP: 1
- all other opcodes: 0
REQ-027 In UPDATE_PC, enable_updatePC SHALL be high for 1 cycle, instr_count SHALL increment by 1 (wrapping from all-ones to 0), and the next state SHALL be FETCH.
REQ-028 A wait counter SHALL clear on entry to each wait state (FETCH, MEM_IND, MEM_READ, MEM_WRITE).
REQ-029 If WAIT_MAX cycles elapse in a wait state with no completion, mem_timeout SHALL set and the FSM SHALL go to UPDATE_PC, aborting the instruction with no writeback.
REQ-030 mem_timeout SHALL clear only on reset.
REQ-031 If completion arrives in the same cycle the counter reaches WAIT_MAX, completion SHALL win and mem_timeout SHALL not set.
REQ-032 Latency with completion signals already high SHALL be:
- ADD/AND/NOT/LEA: 5 cycles
- LD/LDR: 6 cycles
- LDI: 7 cycles
- ST/STR: 5 cycles
- STI: 6 cycles
- BR/JMP/NOP: 4 cycles

Reset
REQ-033 While reset = 1, the following SHALL hold:
- all enables = 0
- W_Control = 0, mem_state = 3
- br_taken = 0, mem_timeout = 0, instr_count = 0
- ir = 0, wait counter = 0
REQ-034 Reset SHALL override every state, including mid-instruction and memory wait states.
REQ-035 The first cycle after reset deasserts SHALL be FETCH, with enable_fetch = 1.

Verification
REQ-036 Scenario ADD: instr_in = 0x1042, complete_instr = 1 -> enables fetch, decode, execute, writeback, updatePC on consecutive cycles; W_Control = 0; instr_count = 1.
REQ-037 Scenario LDI: instr_in = 0xA205, complete_data delayed 3 cycles per access -> mem_state sequence 0, 1; enable_writeback once; W_Control = 1; 13 cycles total.
REQ-038 Scenario branch: BRz instr 0x0403 with psr = 3'b010 -> br_taken = 1; with psr = 3'b100 -> br_taken = 0; enable_writeback never asserted.
REQ-039 Scenario timeout: LD with complete_data held 0 -> after WAIT_MAX = 15 cycles in MEM_READ, mem_timeout = 1, UPDATE_PC follows, no enable_writeback.
REQ-040 Scenario reset mid-operation: reset asserted in MEM_WRITE -> next cycle all outputs at reset values; after release, FETCH with instr_count = 0.
REQ-041 Scenario NOP and wrap: opcode 1101 -> 4-cycle NOP with no writeback; with instr_count preloaded via 2^CNT_W - 1 retirements, the next UPDATE_PC wraps it to 0.
